blur_sequencer: RTL

//  Controller for the Gaussian blur datapath. It owns the kernel generator (CreateKernel) and the

---
 rtl/blur_pkg.sv | 24 ++
 rtl/blur_watchdog.sv | 29 ++
 rtl/blur_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/blur_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blur_pkg
// Summary  : Shared types and defaults for the Gaussian blur sequencer.
// Revision : 1.0
// ============================================================================
package blur_pkg;

  localparam int unsigned BLUR_SIZE    = 5;
  localparam logic [7:0]  BLUR_TIMEOUT = 8'd255;

  typedef logic [BLUR_SIZE-1:0][BLUR_SIZE-1:0][7:0] window_t;

  typedef enum logic [2:0] {
    ST_UNCONF  = 3'd0,
    ST_BUILD   = 3'd1,
    ST_READY   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_OUTPUT  = 3'd4,
    ST_FAULT   = 3'd5
  } blur_state_t;

endpackage
`default_nettype wire

// File: rtl/blur_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : blur_watchdog
// Summary  : 8-bit saturating cycle timer with clear and timeout flag.
// Revision : 1.0
// ============================================================================
module blur_watchdog #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic timeout_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= 8'd0;
    end else if (cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign timeout_o = (cnt_q == TIMEOUT);

endmodule
`default_nettype wire

// File: rtl/blur_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : blur_sequencer
// Summary  : Blur controller: builds the kernel, launches one convolution per
//            accepted window and returns each blurred pixel.
// Revision : 1.0
// ============================================================================
module blur_sequencer
  import blur_pkg::*;
#(
  parameter int unsigned SIZE    = BLUR_SIZE,
  parameter logic [7:0]  TIMEOUT = BLUR_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              cfg_sigma_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_busy_o,
  input  logic                    win_valid_i,
  output logic                    win_ready_o,
  input  logic [SIZE*SIZE*8-1:0]  win_data_i,
  output logic                    pix_valid_o,
  input  logic                    pix_ready_i,
  output logic [7:0]              pix_data_o,
  output logic [15:0]             pix_count_o,
  output logic                    kern_start_o,
  output logic [2:0]              kern_sigma_o,
  input  logic                    kern_done_i,
  input  logic                    kern_err_i,
  output logic                    comp_start_o,
  output logic [SIZE*SIZE*8-1:0]  comp_matrix_o,
  input  logic                    comp_done_i,
  input  logic [7:0]              comp_pixel_i,
  output logic                    err_o
);

  blur_state_t               state_q, state_d;
  logic                      kern_start_q, kern_start_d;
  logic                      comp_start_q;
  logic [2:0]                kern_sigma_q;
  logic                      pend_q;
  logic [2:0]                pend_sigma_q;
  logic [SIZE*SIZE*8-1:0]    comp_matrix_q;
  logic                      pix_valid_q;
  logic [7:0]                pix_data_q;
  logic [15:0]               pix_count_q;
  logic                      err_q;

  logic                      timeout;
  logic                      wd_clr;
  logic                      win_hs;
  logic                      build_ok;
  logic                      pend_now;
  logic [2:0]                pend_sigma_now;

  // A cfg_valid arriving this cycle counts as pending and wins over an older one.
  assign pend_now       = pend_q | cfg_valid_i;
  assign pend_sigma_now = cfg_valid_i ? cfg_sigma_i : pend_sigma_q;
  assign win_hs         = (state_q == ST_READY) && !cfg_valid_i && win_valid_i;
  assign build_ok       = (state_q == ST_BUILD) && kern_done_i && !kern_err_i && !timeout;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNCONF, ST_FAULT: if (cfg_valid_i) state_d = ST_BUILD;
      ST_BUILD: begin
        if (kern_err_i || timeout) state_d = ST_FAULT;
        else if (kern_done_i)      state_d = pend_now ? ST_BUILD : ST_READY;
      end
      ST_READY: begin
        if (cfg_valid_i)      state_d = ST_BUILD;
        else if (win_valid_i) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (comp_done_i)  state_d = ST_OUTPUT;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_OUTPUT: if (pix_ready_i) state_d = pend_now ? ST_BUILD : ST_READY;
      default: state_d = ST_UNCONF;
    endcase
  end

  // A finished build followed directly by another build still needs a fresh start.
  assign kern_start_d = (state_d == ST_BUILD) && ((state_q != ST_BUILD) || kern_done_i);
  assign wd_clr       = (state_d != state_q) || kern_start_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_UNCONF;
      kern_start_q  <= 1'b0;
      comp_start_q  <= 1'b0;
      kern_sigma_q  <= 3'd0;
      pend_q        <= 1'b0;
      pend_sigma_q  <= 3'd0;
      comp_matrix_q <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= 8'd0;
      pix_count_q   <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      kern_start_q <= kern_start_d;
      comp_start_q <= win_hs;

      if (kern_start_d) kern_sigma_q <= pend_sigma_now;

      if (kern_start_d || (state_d == ST_FAULT)) begin
        pend_q <= 1'b0;
      end else if (cfg_valid_i && (state_q == ST_BUILD || state_q == ST_COMPUTE ||
                                   state_q == ST_OUTPUT)) begin
        pend_q       <= 1'b1;
        pend_sigma_q <= cfg_sigma_i;
      end

      if (win_hs) comp_matrix_q <= win_data_i;

      if (state_q == ST_COMPUTE && comp_done_i) begin
        pix_data_q  <= comp_pixel_i;
        pix_valid_q <= 1'b1;
      end else if (state_q == ST_OUTPUT && pix_ready_i) begin
        pix_valid_q <= 1'b0;
        pix_count_q <= pix_count_q + 16'd1;
      end

      if (build_ok) begin
        err_q       <= 1'b0;
        pix_count_q <= 16'd0;
      end else if (state_d == ST_FAULT && state_q != ST_FAULT) begin
        err_q <= 1'b1;
      end
    end
  end

  blur_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .timeout_o (timeout)
  );

  assign cfg_busy_o    = (state_q == ST_BUILD) || pend_q;
  assign win_ready_o   = (state_q == ST_READY) && !cfg_valid_i;
  assign pix_valid_o   = pix_valid_q;
  assign pix_data_o    = pix_data_q;
  assign pix_count_o   = pix_count_q;
  assign kern_start_o  = kern_start_q;
  assign kern_sigma_o  = kern_sigma_q;
  assign comp_start_o  = comp_start_q;
  assign comp_matrix_o = comp_matrix_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire
